round_shift_div: RTL and testbench
==================================

ROUND_SHIFT_DIV -- requirements
Module: round_shift_div

Interface
REQ-001 SHALL have parameter IN_W, default 16, dividend width (>=2).
REQ-002 SHALL have parameter OUT_W, default 8, quotient width (1..IN_W).
REQ-003 SHALL have parameter SH_W, default 5, shift-amount width; n range 0..2^SH_W-1.
REQ-004 SHALL have parameter CNT_W, default 16, saturation-counter width.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port in_valid  input  1  request valid.
REQ-008 SHALL have port in_ready  output  1  request accepted when in_valid & in_ready.
REQ-009 SHALL have port in_data  input  IN_W  unsigned dividend.
REQ-010 SHALL have port in_n  input  SH_W  divide by 2^in_n.
REQ-011 SHALL have port in_mode  input  2  rounding mode: 0 TRUNC, 1 HALF_UP, 2 HALF_EVEN, 3 CEIL.
REQ-012 SHALL have port out_valid  output  1  result valid.
REQ-013 SHALL have port out_ready  input  1  result consumed when out_valid & out_ready.
REQ-014 SHALL have port out_data  output  OUT_W  rounded, saturated quotient.
REQ-015 SHALL have port out_sat  output  1  result was clamped.
REQ-016 SHALL have port sat_cnt  output  CNT_W  count of consumed saturated results.
REQ-017 SHALL have port sat_clr  input  1  synchronous clear of sat_cnt.

Function
REQ-018 SHALL be a two-stage pipeline: S1 registers in_data/in_n/in_mode on acceptance; S2 registers the computed result; latency 2 cycles from acceptance to out_valid when unstalled.
REQ-019 SHALL advance S2 when !s2_valid or out_ready; S1 advances when !s1_valid or S2 advances; in_ready = !s1_valid or S1 advances; full throughput 1 result/cycle.
REQ-020 SHALL hold out_data/out_sat stable while out_valid & !out_ready; no loss, no duplication, order preserved.
REQ-021 SHALL compute q = in_data >> n, R = bit n-1 (0 if n=0 or n>IN_W), S = OR of bits below n-1 (all bits when n>IN_W).
REQ-022 SHALL increment q when: TRUNC never; HALF_UP R; HALF_EVEN R & (S | q[0]); CEIL R | S.
REQ-023 SHALL, for n=0, pass in_data unrounded in all modes.
REQ-024 SHALL compute the increment at IN_W+1 bits (no wrap), then clamp: if result > 2^OUT_W-1, out_data = all ones and out_sat = 1, else out_data = result[OUT_W-1:0], out_sat = 0.
REQ-025 SHALL increment sat_cnt on each out_valid & out_ready & out_sat, saturating at all ones (no wrap).
REQ-026 SHALL give sat_clr priority over a simultaneous increment (result 0).

Reset
REQ-027 SHALL on rst_n low clear s1_valid, s2_valid (out_valid=0), out_data=0, out_sat=0, sat_cnt=0 asynchronously.
REQ-028 SHALL drop in-flight transactions on reset mid-operation; in_ready=1 from first clk after release.

Structure
REQ-029 SHALL define the rounding-mode enum (TRUNC/HALF_UP/HALF_EVEN/CEIL) in package round_shift_div_pkg.
REQ-030 SHALL place the combinational shift/round/clamp datapath in sub-module rsd_round_core, instantiated once between S1 and S2.

Verification (IN_W=16, OUT_W=8, SH_W=5)
REQ-031 SHALL check in_data=0x00B8, n=4, HALF_UP, out_ready=1 -> out_data=0x0C, out_sat=0, out_valid exactly 2 cycles after acceptance.
REQ-032 SHALL check HALF_EVEN n=4: 0x0028 -> 0x02; 0x0038 -> 0x04; TRUNC 0x0038 -> 0x03; CEIL 0x0031 -> 0x04.
REQ-033 SHALL check in_data=0xFFFF, n=2, HALF_UP -> out_data=0xFF, out_sat=1, sat_cnt 0->1 on consumption; sat_clr same cycle -> sat_cnt=0.
REQ-034 SHALL check in_data=0x8000: n=16 HALF_UP -> 0x01, TRUNC -> 0x00; n=20 CEIL -> 0x01, HALF_UP -> 0x00.
REQ-035 SHALL check back-pressure: 5 back-to-back requests, out_ready=0 for 6 cycles -> in_ready low after 2 accepted, all 5 results delivered in order, outputs stable while stalled.
REQ-036 SHALL check rst_n pulse with both stages full -> out_valid=0 immediately, sat_cnt=0, no stale result after release.

Source files
------------

// File: rtl/round_shift_div_pkg.sv
// ============================================================================
// Module   : round_shift_div_pkg
// Brief    : Shared types for the round-shift divider.
// Revision : 1.0
// ============================================================================
`default_nettype none

package round_shift_div_pkg;

    typedef enum logic [1:0] {
        TRUNC     = 2'd0,
        HALF_UP   = 2'd1,
        HALF_EVEN = 2'd2,
        CEIL      = 2'd3
    } rsd_mode_e;

endpackage

`default_nettype wire

// File: rtl/rsd_round_core.sv
// ============================================================================
// Module   : rsd_round_core
// Brief    : Combinational divide by 2^n with selectable rounding and clamp.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rsd_round_core
    import round_shift_div_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SH_W  = 5
) (
    input  logic [IN_W-1:0]  data_i,
    input  logic [SH_W-1:0]  n_i,
    input  rsd_mode_e        mode_i,
    output logic [OUT_W-1:0] res_o,
    output logic             sat_o
);

    logic [31:0]   n_wide;
    logic [IN_W-1:0] q;
    logic          round_bit;
    logic          sticky;
    logic          inc;
    logic [IN_W:0] sum;

    assign n_wide = 32'(n_i);
    assign q      = data_i >> n_i;

    // Round bit is data[n-1]; sticky covers everything below it. Shifts past
    // IN_W leave round_bit clear and fold the whole word into sticky.
    always_comb begin
        round_bit = 1'b0;
        sticky    = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (n_wide == 32'(i + 1)) begin
                round_bit = data_i[i];
            end
            if (n_wide >= 32'(i + 2)) begin
                sticky = sticky | data_i[i];
            end
        end
    end

    always_comb begin
        inc = 1'b0;
        case (mode_i)
            TRUNC:     inc = 1'b0;
            HALF_UP:   inc = round_bit;
            HALF_EVEN: inc = round_bit & (sticky | q[0]);
            CEIL:      inc = round_bit | sticky;
            default:   inc = 1'b0;
        endcase
    end

    assign sum   = {1'b0, q} + {{IN_W{1'b0}}, inc};
    assign sat_o = |sum[IN_W:OUT_W];
    assign res_o = sat_o ? {OUT_W{1'b1}} : sum[OUT_W-1:0];

endmodule

`default_nettype wire

// File: rtl/round_shift_div.sv
// ============================================================================
// Module   : round_shift_div
// Brief    : Two-stage valid/ready pipeline dividing by 2^n with rounding,
//            saturation and a saturation event counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module round_shift_div
    import round_shift_div_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 8,
    parameter int SH_W  = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [SH_W-1:0]  in_n,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_sat,
    output logic [CNT_W-1:0] sat_cnt,
    input  logic             sat_clr
);

    logic             s1_valid_q, s1_valid_d;
    logic [IN_W-1:0]  s1_data_q,  s1_data_d;
    logic [SH_W-1:0]  s1_n_q,     s1_n_d;
    rsd_mode_e        s1_mode_q,  s1_mode_d;
    logic             s2_valid_q, s2_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             out_sat_q,  out_sat_d;
    logic [CNT_W-1:0] sat_cnt_q,  sat_cnt_d;

    logic             s2_adv;
    logic             s1_adv;
    logic             accept;
    logic [OUT_W-1:0] core_res;
    logic             core_sat;

    assign s2_adv = !s2_valid_q || out_ready;
    assign s1_adv = !s1_valid_q || s2_adv;
    assign accept = in_valid && s1_adv;

    rsd_round_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SH_W  (SH_W)
    ) u_core (
        .data_i (s1_data_q),
        .n_i    (s1_n_q),
        .mode_i (s1_mode_q),
        .res_o  (core_res),
        .sat_o  (core_sat)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_data_d  = s1_data_q;
        s1_n_d     = s1_n_q;
        s1_mode_d  = s1_mode_q;
        s2_valid_d = s2_valid_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        sat_cnt_d  = sat_cnt_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_data_d = in_data;
            s1_n_d    = in_n;
            s1_mode_d = rsd_mode_e'(in_mode);
        end

        // Result registers only load a real result, so a stalled or empty
        // output keeps its last value on out_data/out_sat.
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = core_res;
                out_sat_d  = core_sat;
            end
        end

        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (s2_valid_q && out_ready && out_sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_data_q  <= '0;
            s1_n_q     <= '0;
            s1_mode_q  <= TRUNC;
            s2_valid_q <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
            sat_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_data_q  <= s1_data_d;
            s1_n_q     <= s1_n_d;
            s1_mode_q  <= s1_mode_d;
            s2_valid_q <= s2_valid_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
            sat_cnt_q  <= sat_cnt_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_round_shift_div.sv
// ============================================================================
// Module   : tb_round_shift_div
// Brief    : Self-checking bench for round_shift_div with a reference model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_round_shift_div;

    localparam int IN_W  = 16;
    localparam int OUT_W = 8;
    localparam int SH_W  = 5;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [SH_W-1:0]  in_n;
    logic [1:0]       in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic             out_sat;
    logic [CNT_W-1:0] sat_cnt;
    logic             sat_clr;

    round_shift_div #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SH_W  (SH_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_n      (in_n),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .sat_cnt   (sat_cnt),
        .sat_clr   (sat_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       s;
    } exp_t;

    int         total = 0;
    int         bad   = 0;
    exp_t       expq[$];
    logic       hold_v;
    logic [7:0] hold_d;
    logic       hold_s;
    logic [15:0] cnt_model;
    logic       acc_f;
    logic [7:0] last_d;
    logic       last_s;

    // Reference: integer division by 2^n with the remainder deciding rounding.
    function automatic exp_t model(int unsigned data, int unsigned n, int unsigned mode);
        longint unsigned div, q, rem, half, r;
        bit inc;
        exp_t e;
        div  = 64'd1 << n;
        q    = data / div;
        rem  = data % div;
        half = div / 2;
        inc  = 1'b0;
        if (n != 0) begin
            case (mode)
                1: inc = (rem >= half);
                2: inc = (rem > half) || ((rem == half) && (q % 2 == 1));
                3: inc = (rem != 0);
                default: inc = 1'b0;
            endcase
        end
        r   = q + (inc ? 64'd1 : 64'd0);
        e.s = (r > 255);
        e.d = e.s ? 8'hFF : r[7:0];
        return e;
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One clock: sample at the falling edge, update the model, return at posedge+1.
    task automatic step();
        exp_t e;
        @(negedge clk);
        if (hold_v) begin
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, hold_d);
            check("hold_sat", out_sat, hold_s);
        end
        check("sat_cnt", sat_cnt, cnt_model);
        hold_v = out_valid & ~out_ready;
        hold_d = out_data;
        hold_s = out_sat;
        if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
                check("unexpected_out", 1, 0);
            end else begin
                e = expq.pop_front();
                check("out_data", out_data, e.d);
                check("out_sat", out_sat, e.s);
                last_d = out_data;
                last_s = out_sat;
                if (out_sat && cnt_model != 16'hFFFF) cnt_model++;
            end
        end
        if (sat_clr) cnt_model = '0;
        acc_f = in_valid & in_ready;
        if (acc_f) expq.push_back(model(in_data, in_n, in_mode));
        @(posedge clk);
        #1;
    endtask

    task automatic put(logic [15:0] d, logic [4:0] n, logic [1:0] m);
        int k;
        in_data  = d;
        in_n     = n;
        in_mode  = m;
        in_valid = 1'b1;
        k = 0;
        do begin
            step();
            k++;
        end while (!acc_f && k < 50);
        check("accept_timeout", acc_f, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int i = 0; i < 60 && expq.size() > 0; i++) step();
        check("drain_timeout", expq.size(), 0);
    endtask

    typedef struct {
        logic [15:0] d;
        logic [4:0]  n;
        logic [1:0]  m;
        logic [7:0]  r;
    } vec_t;

    vec_t vecs[8];
    int   idx;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_n      = '0;
        in_mode   = '0;
        out_ready = 1'b0;
        sat_clr   = 1'b0;
        hold_v    = 1'b0;
        cnt_model = '0;
        acc_f     = 1'b0;
        last_d    = '0;
        last_s    = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", in_ready, 1);

        // Basic latency: 0x00B8 / 16 half-up = 0x0C, visible two cycles after acceptance
        out_ready = 1'b1;
        put(16'h00B8, 5'd4, 2'd1);
        check("lat_c1_valid", out_valid, 0);
        step();
        check("lat_c2_valid", out_valid, 1);
        check("lat_c2_data", out_data, 8'h0C);
        check("lat_c2_sat", out_sat, 0);
        drain();

        // Directed rounding cases, including shifts at and beyond the width
        vecs[0] = '{16'h0028, 5'd4,  2'd2, 8'h02};
        vecs[1] = '{16'h0038, 5'd4,  2'd2, 8'h04};
        vecs[2] = '{16'h0038, 5'd4,  2'd0, 8'h03};
        vecs[3] = '{16'h0031, 5'd4,  2'd3, 8'h04};
        vecs[4] = '{16'h8000, 5'd16, 2'd1, 8'h01};
        vecs[5] = '{16'h8000, 5'd16, 2'd0, 8'h00};
        vecs[6] = '{16'h8000, 5'd20, 2'd3, 8'h01};
        vecs[7] = '{16'h8000, 5'd20, 2'd1, 8'h00};
        for (int i = 0; i < 8; i++) begin
            put(vecs[i].d, vecs[i].n, vecs[i].m);
            drain();
            check($sformatf("vec%0d_data", i), last_d, vecs[i].r);
            check($sformatf("vec%0d_sat", i), last_s, 0);
        end

        // n = 0 passes through unrounded
        put(16'h00A7, 5'd0, 2'd3);
        drain();
        check("n0_data", last_d, 8'hA7);

        // Saturation and counter
        put(16'hFFFF, 5'd2, 2'd1);
        drain();
        check("sat_data", last_d, 8'hFF);
        check("sat_flag", last_s, 1);
        check("sat_cnt_one", sat_cnt, 1);
        out_ready = 1'b0;
        put(16'hFFFF, 5'd2, 2'd1);
        for (int i = 0; i < 10 && !out_valid; i++) step();
        check("sat2_valid", out_valid, 1);
        out_ready = 1'b1;
        sat_clr   = 1'b1;
        step();
        sat_clr   = 1'b0;
        check("sat_clr_prio", sat_cnt, 0);
        drain();

        // Back-pressure: five requests with the output stalled for six cycles
        out_ready = 1'b0;
        idx = 0;
        for (int i = 0; i < 6; i++) begin
            in_data  = 16'($urandom);
            in_n     = 5'($urandom_range(0, 8));
            in_mode  = 2'($urandom);
            in_valid = 1'b1;
            step();
            if (acc_f) idx++;
        end
        check("bp_accepted", idx, 2);
        check("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        for (int i = 0; i < 40 && idx < 5; i++) begin
            step();
            if (acc_f) begin
                idx++;
                in_data = 16'($urandom);
                in_n    = 5'($urandom_range(0, 8));
                in_mode = 2'($urandom);
            end
        end
        in_valid = 1'b0;
        check("bp_all_accepted", idx, 5);
        drain();

        // Randomized traffic with random back-pressure and occasional clears
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom);
            in_data   = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 4095)) : 16'($urandom);
            in_n      = 5'($urandom);
            in_mode   = 2'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            sat_clr   = ($urandom_range(0, 31) == 0);
            step();
        end
        in_valid = 1'b0;
        sat_clr  = 1'b0;
        drain();

        // Reset with both stages full
        put(16'hFFFF, 5'd0, 2'd0);
        drain();
        check("pre_rst_cnt_nonzero", (sat_cnt != 0), 1);
        out_ready = 1'b0;
        put(16'h1234, 5'd3, 2'd1);
        put(16'h0F0F, 5'd1, 2'd2);
        check("full_valid", out_valid, 1);
        check("full_in_ready", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_sat_cnt", sat_cnt, 0);
        check("arst_out_data", out_data, 0);
        expq.delete();
        cnt_model = '0;
        hold_v    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_no_stale", out_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
